row_streamer: RTL and testbench
===============================

# row_streamer

Consumes the row timing from `TurnTimer` and drives one row of pixels into the blade's serial LED drivers. On each accepted `rowChange`, it reads `IMG_WIDTH` pixels for the current `{index, row}` from frame memory, one synchronous read at a time. It shifts each pixel out MSB-first on a clock/data pair, then pulses a latch. It sits between `TurnTimer` and the LED driver chain.

## Interface
- `IMG_HEIGHT`, 1024, rows per revolution; must match `TurnTimer`.
- `IMG_WIDTH`, 64, pixels per row; power of two.
- `PIX_BITS`, 24, bits per pixel.
- `CLK_DIV`, 1, `clk` cycles per `ledClk` half-period; must be ≥1.
- `clk`  in  1  system clock.
- `nReset`  in  1  reset, asynchronous, active-low.
- `row`  in  $clog2(IMG_HEIGHT)  row number from `TurnTimer`.
- `index`  in  1  blade side / frame bank select.
- `valid`  in  1  rotation timing locked.
- `rowChange`  in  1  single-cycle strobe: a new row begins.
- `memAddr`  out  1+$clog2(IMG_HEIGHT)+$clog2(IMG_WIDTH)  address `{index,row,col}`.
- `memRdEn`  out  1  read strobe.
- `memData`  in  PIX_BITS  read data; valid the cycle after `memRdEn`.
- `ledClk`  out  1  serial clock; the driver samples on the rising edge.
- `ledData`  out  1  serial data.
- `ledLatch`  out  1  latch pulse.
- `busy`  out  1  high in every state except IDLE.
- `overrun`  out  1  one-cycle pulse when a `rowChange` is dropped.

## Operation
- FSM states: IDLE, FETCH, WAIT, SHIFT, LATCH.
- IDLE: on `rowChange && valid`:
  - capture `row` and `index`;
  - set `col=0`;
  - go to FETCH on the next cycle.
  - `rowChange && !valid` is ignored; see Configuration.
- FETCH (1 cycle): `memRdEn=1`, `memAddr={idx_q,row_q,col}`.
- WAIT (1 cycle): `memData` is loaded into the PIX_BITS shift register at the end of this cycle.
- SHIFT: PIX_BITS bits, MSB first. Each bit takes 2·CLK_DIV cycles:
  - `ledClk` is low for CLK_DIV cycles, with `ledData` set to the current MSB;
  - `ledClk` is then high for CLK_DIV cycles;
  - the register shifts left at the end of the high phase.
- After the last bit:
  - if `col==IMG_WIDTH-1`, go to LATCH;
  - otherwise `col++` and go to FETCH.
- LATCH: `ledLatch=1` for 2·CLK_DIV cycles, `ledClk=0`, then return to IDLE.
- `rowChange` outside IDLE, including the final LATCH cycle, is dropped with a one-cycle `overrun`. Requests are never queued.
- `col` never wraps inside a row; it is reset on each accept.

## Timing
- Reset values:
  - all outputs 0: `memAddr`, `memRdEn`, `ledClk`, `ledData`, `ledLatch`, `busy`, `overrun`;
  - state IDLE; shift register 0.
- Accept → first `memRdEn`: 1 cycle.
- `busy` rises the cycle after accept. It stays high for IMG_WIDTH·(2+2·CLK_DIV·PIX_BITS)+2·CLK_DIV cycles; defaults give 3202.
- The row budget at 50 MHz / 10 FPS / 1024 rows is about 4882 cycles, so the defaults fit.
- `ledData` changes only while `ledClk` is low. `ledClk` is 0 whenever not in SHIFT.
- `overrun` is registered and asserts the cycle after the offending `rowChange`.
- Reset mid-row: all outputs drop to 0 immediately and asynchronously. A partial row is never latched.

## Configuration
- `ROW_STREAMER_BLANK_EN` defined:
  - `rowChange && !valid` in IDLE is accepted as a blank row;
  - the full FSM runs with identical timing;
  - `memRdEn` stays 0 and the shift register loads 0, so the LEDs go dark when rotation is not locked.
- Not defined: such strobes are ignored and the LEDs hold the last latched row.

## Structure
- Shared package `display_pkg`:
  - `row_state_t` enum (IDLE, FETCH, WAIT, SHIFT, LATCH);
  - `ADDR_W` width function;
  - `IMG_HEIGHT` / `IMG_WIDTH` defaults, shared with `TurnTimer`.
- One sub-module, `led_shifter`:
  - loads a PIX_BITS word;
  - generates `ledClk`/`ledData` with CLK_DIV;
  - reports `done`.
- FSM, column counter and memory interface stay in `row_streamer`.

## Test plan
- Reset mid-row:
  - stimulus: assert `nReset=0` at cycle 500 of a row;
  - response: all outputs 0 within the same cycle; no `ledLatch` pulse; the next accepted `rowChange` fetches `col=0`.
- Basic row:
  - stimulus: `row=5`, `index=1`, `valid=1`, one `rowChange`; memory returns `0xA5A5A5` for col 0;
  - response: first `memAddr={1,5,0}`; `ledData` shows `1,0,1,0,0,1,0,1…` on 24 rising edges; exactly 64 `memRdEn` pulses; one 2-cycle `ledLatch`; `busy` high for 3202 cycles.
- Overrun:
  - stimulus: a second `rowChange` 100 cycles after the first, and another on the final LATCH cycle;
  - response: two `overrun` pulses; the first row completes unchanged; no second row starts.
- Invalid rotation:
  - stimulus: `rowChange` with `valid=0`;
  - response without the macro: `busy` stays 0;
  - response with `ROW_STREAMER_BLANK_EN`: 3202 busy cycles, zero `memRdEn` pulses, `ledData` always 0, one latch pulse.
- Divider:
  - stimulus: `CLK_DIV=3`, `IMG_WIDTH=4`, `PIX_BITS=8`;
  - response: `ledClk` period 6 cycles; `busy` lasts 4·(2+48)+6 = 206 cycles.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display types and geometry defaults used by row_streamer and TurnTimer.
package display_pkg;

  localparam int IMG_HEIGHT = 1024;
  localparam int IMG_WIDTH  = 64;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    WAIT,
    SHIFT,
    LATCH
  } row_state_t;

  // Frame memory address is {index, row, col}.
  function automatic int ADDR_W(input int height, input int width);
    return 1 + $clog2(height) + $clog2(width);
  endfunction

endpackage

// File: rtl/led_shifter.sv
// Serialises one PIX_BITS word MSB-first on ledClk/ledData; each bit is CLK_DIV low then CLK_DIV high.
module led_shifter #(
  parameter int PIX_BITS = 24,
  parameter int CLK_DIV  = 1
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic                load,
  input  logic [PIX_BITS-1:0] load_data,
  output logic                ledClk,
  output logic                ledData,
  output logic                done
);

  localparam int DIV_W = $clog2(CLK_DIV + 1);
  localparam int BIT_W = $clog2(PIX_BITS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PIX_BITS - 1);

  logic [PIX_BITS-1:0] sr_q, sr_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic                high_q, high_d;
  logic                active_q, active_d;
  logic                phase_end;

  always_comb begin
    sr_d      = sr_q;
    div_d     = div_q;
    bit_d     = bit_q;
    high_d    = high_q;
    active_d  = active_q;
    phase_end = active_q && (div_q == DIV_LAST);
    done      = phase_end && high_q && (bit_q == BIT_LAST);
    if (load) begin
      sr_d     = load_data;
      div_d    = '0;
      bit_d    = '0;
      high_d   = 1'b0;
      active_d = 1'b1;
    end else if (active_q) begin
      if (phase_end) begin
        div_d  = '0;
        high_d = !high_q;
        // Shift at the end of the high phase so data only moves while ledClk is low.
        if (high_q) begin
          sr_d  = {sr_q[PIX_BITS-2:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_LAST) active_d = 1'b0;
        end
      end else begin
        div_d = div_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      sr_q     <= '0;
      div_q    <= '0;
      bit_q    <= '0;
      high_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      sr_q     <= sr_d;
      div_q    <= div_d;
      bit_q    <= bit_d;
      high_q   <= high_d;
      active_q <= active_d;
    end
  end

  assign ledClk  = active_q && high_q;
  assign ledData = active_q && sr_q[PIX_BITS-1];

endmodule

// File: rtl/row_streamer.sv
// Streams one row of IMG_WIDTH pixels from frame memory to the LED driver chain per rowChange.
// Define ROW_STREAMER_BLANK_EN to stream a dark row when rowChange arrives while rotation is not locked.
module row_streamer #(
  parameter int IMG_HEIGHT = display_pkg::IMG_HEIGHT,
  parameter int IMG_WIDTH  = display_pkg::IMG_WIDTH,
  parameter int PIX_BITS   = 24,
  parameter int CLK_DIV    = 1
) (
  input  logic                                                  clk,
  input  logic                                                  nReset,
  input  logic [$clog2(IMG_HEIGHT)-1:0]                         row,
  input  logic                                                  index,
  input  logic                                                  valid,
  input  logic                                                  rowChange,
  output logic [display_pkg::ADDR_W(IMG_HEIGHT, IMG_WIDTH)-1:0] memAddr,
  output logic                                                  memRdEn,
  input  logic [PIX_BITS-1:0]                                   memData,
  output logic                                                  ledClk,
  output logic                                                  ledData,
  output logic                                                  ledLatch,
  output logic                                                  busy,
  output logic                                                  overrun,
  output display_pkg::row_state_t                               dbg_state
);
  import display_pkg::*;

  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int LAT_W = $clog2(2 * CLK_DIV);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(2 * CLK_DIV - 1);

  row_state_t       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             idx_q, idx_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [LAT_W-1:0] lat_q, lat_d;
  logic             overrun_q;
  logic             accept, blank_row, load, shift_done;

`ifdef ROW_STREAMER_BLANK_EN
  logic blank_q;
  assign accept = (state_q == IDLE) && rowChange;
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset)     blank_q <= 1'b0;
    else if (accept) blank_q <= !valid;
  end
  assign blank_row = blank_q;
`else
  assign accept    = (state_q == IDLE) && rowChange && valid;
  assign blank_row = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    idx_d    = idx_q;
    col_d    = col_q;
    lat_d    = lat_q;
    load     = 1'b0;
    memRdEn  = 1'b0;
    ledLatch = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        row_d   = row;
        idx_d   = index;
        col_d   = '0;
        state_d = FETCH;
      end
      FETCH: begin
        memRdEn = !blank_row;
        state_d = WAIT;
      end
      WAIT: begin
        load    = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: if (shift_done) begin
        if (col_q == COL_LAST) begin
          state_d = LATCH;
        end else begin
          col_d   = col_q + 1'b1;
          state_d = FETCH;
        end
      end
      LATCH: begin
        ledLatch = 1'b1;
        if (lat_q == LAT_LAST) begin
          lat_d   = '0;
          state_d = IDLE;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      row_q     <= '0;
      idx_q     <= 1'b0;
      col_q     <= '0;
      lat_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      idx_q     <= idx_d;
      col_q     <= col_d;
      lat_q     <= lat_d;
      overrun_q <= rowChange && (state_q != IDLE);
    end
  end

  led_shifter #(
    .PIX_BITS (PIX_BITS),
    .CLK_DIV  (CLK_DIV)
  ) u_shifter (
    .clk       (clk),
    .nReset    (nReset),
    .load      (load),
    .load_data (blank_row ? '0 : memData),
    .ledClk    (ledClk),
    .ledData   (ledData),
    .done      (shift_done)
  );

  assign memAddr   = {idx_q, row_q, col_q};
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_row_streamer.sv
// Self-checking bench for row_streamer: default geometry plus a small divided-clock instance.
module tb_row_streamer;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic [9:0]  row = '0;
  logic        index = 1'b0;
  logic        valid = 1'b0;
  logic        rowChange = 1'b0;
  logic [16:0] memAddr;
  logic        memRdEn;
  logic [23:0] memData = '0;
  logic        ledClk, ledData, ledLatch, busy, overrun;
  display_pkg::row_state_t dbg_state;

  logic        d_rowChange = 1'b0;
  logic [12:0] d_memAddr;
  logic        d_memRdEn;
  logic [7:0]  d_memData = '0;
  logic        d_ledClk, d_ledData, d_ledLatch, d_busy, d_overrun;
  display_pkg::row_state_t d_dbg_state;

  int checks = 0;
  int failures = 0;
  logic [16:0] exp_addr_q[$];
  logic        exp_q[$];

  always #5 clk = ~clk;

  row_streamer dut (
    .clk(clk), .nReset(nReset), .row(row), .index(index), .valid(valid),
    .rowChange(rowChange), .memAddr(memAddr), .memRdEn(memRdEn), .memData(memData),
    .ledClk(ledClk), .ledData(ledData), .ledLatch(ledLatch), .busy(busy),
    .overrun(overrun), .dbg_state(dbg_state)
  );

  row_streamer #(.IMG_HEIGHT(1024), .IMG_WIDTH(4), .PIX_BITS(8), .CLK_DIV(3)) dut_div (
    .clk(clk), .nReset(nReset), .row(row), .index(index), .valid(valid),
    .rowChange(d_rowChange), .memAddr(d_memAddr), .memRdEn(d_memRdEn), .memData(d_memData),
    .ledClk(d_ledClk), .ledData(d_ledData), .ledLatch(d_ledLatch), .busy(d_busy),
    .overrun(d_overrun), .dbg_state(d_dbg_state)
  );

  function automatic logic [23:0] pix(input logic [16:0] a);
    if (a[5:0] == 6'd0) return 24'hA5A5A5;
    return {a[7:0] ^ 8'h5A, a[15:8], 2'b01, a[5:0]};
  endfunction

  function automatic logic [7:0] d_pix(input logic [1:0] c);
    return 8'h96 ^ {6'b0, c};
  endfunction

  // Frame memory model: one-cycle synchronous read.
  always @(posedge clk) begin
    if (memRdEn) memData <= pix(memAddr);
    if (d_memRdEn) d_memData <= d_pix(d_memAddr[1:0]);
  end

  // Runs one row on the default instance and scoreboards addresses and serial bits.
  task automatic run_row(input logic [9:0] r, input logic ix, input logic v, input bit blank,
                         input bit inject, output int busy_n, output int rd_n,
                         output int latch_n, output int ovr_n);
    bit seen = 0;
    bit done_ok = 0;
    logic prev_clk = 1'b0;
    logic prev_data = 1'b0;
    logic [16:0] ea;
    logic [23:0] px;
    logic eb;
    busy_n = 0; rd_n = 0; latch_n = 0; ovr_n = 0;
    if (!blank) for (int c = 0; c < 64; c++) exp_addr_q.push_back({ix, r, 6'(c)});
    row = r; index = ix; valid = v; rowChange = 1'b1;
    @(negedge clk);
    rowChange = 1'b0;
    for (int cyc = 0; cyc < 5000; cyc++) begin
      if (overrun) ovr_n++;
      if (busy) begin
        busy_n++;
        seen = 1;
      end else if (seen) begin
        done_ok = 1;
        break;
      end
      if (memRdEn) begin
        rd_n++;
        checks++;
        if (exp_addr_q.size() == 0) begin
          failures++;
          $display("FAIL mem_addr unexpected read got=%h", memAddr);
          ea = memAddr;
        end else begin
          ea = exp_addr_q.pop_front();
          if (memAddr !== ea) begin
            failures++;
            $display("FAIL mem_addr got=%h exp=%h", memAddr, ea);
          end
        end
        px = pix(ea);
        for (int b = 23; b >= 0; b--) exp_q.push_back(px[b]);
      end
      if (ledClk && !prev_clk) begin
        checks++;
        if (blank) eb = 1'b0;
        else if (exp_q.size() == 0) eb = 1'bx;
        else eb = exp_q.pop_front();
        if (ledData !== eb) begin
          failures++;
          $display("FAIL led_bit cyc=%0d got=%b exp=%b", cyc, ledData, eb);
        end
      end
      if (prev_clk && ledClk) begin
        checks++;
        if (ledData !== prev_data) begin
          failures++;
          $display("FAIL data_while_clk_high cyc=%0d got=%b exp=%b", cyc, ledData, prev_data);
        end
      end
      if (ledLatch) latch_n++;
      if (inject && cyc == 100) begin
        row = r + 10'd1;
        rowChange = 1'b1;
      end
      if (inject && ledLatch && latch_n == 2) rowChange = 1'b1;
      prev_clk = ledClk;
      prev_data = ledData;
      @(negedge clk);
      rowChange = 1'b0;
      row = r;
    end
    checks++;
    if (!done_ok) begin
      failures++;
      $display("FAIL row_timeout got=busy exp=idle");
    end
    for (int t = 0; t < 6; t++) begin
      @(negedge clk);
      if (overrun) ovr_n++;
      checks++;
      if (busy !== 1'b0) begin
        failures++;
        $display("FAIL no_restart t=%0d got busy=%b exp=0", t, busy);
      end
    end
    checks++;
    if (exp_addr_q.size() != 0 || exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got addr=%0d bits=%0d exp=0", exp_addr_q.size(), exp_q.size());
    end
    exp_addr_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset;
    nReset = 1'b0;
    #1;
    checks++;
    if ({memAddr, memRdEn, ledClk, ledData, ledLatch, busy, overrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0", {memAddr, memRdEn, ledClk, ledData, ledLatch, busy, overrun});
    end
    checks++;
    if ({d_memAddr, d_memRdEn, d_ledClk, d_ledData, d_ledLatch, d_busy, d_overrun} !== '0) begin
      failures++;
      $display("FAIL reset_outputs_div got=%h exp=0", {d_memAddr, d_memRdEn, d_ledClk, d_ledData, d_ledLatch, d_busy, d_overrun});
    end
    checks++;
    if (dbg_state !== display_pkg::IDLE) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=%0d", dbg_state, display_pkg::IDLE);
    end
    repeat (2) @(negedge clk);
    nReset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int b_n, r_n, l_n, o_n;
    run_row(10'd5, 1'b1, 1'b1, 1'b0, 1'b0, b_n, r_n, l_n, o_n);
    checks++;
    if (b_n !== 3202) begin failures++; $display("FAIL basic_busy got=%0d exp=3202", b_n); end
    checks++;
    if (r_n !== 64) begin failures++; $display("FAIL basic_reads got=%0d exp=64", r_n); end
    checks++;
    if (l_n !== 2) begin failures++; $display("FAIL basic_latch got=%0d exp=2", l_n); end
    checks++;
    if (o_n !== 0) begin failures++; $display("FAIL basic_overrun got=%0d exp=0", o_n); end
  endtask

  task automatic test_overrun;
    int b_n, r_n, l_n, o_n;
    run_row(10'd9, 1'b0, 1'b1, 1'b0, 1'b1, b_n, r_n, l_n, o_n);
    checks++;
    if (o_n !== 2) begin failures++; $display("FAIL overrun_pulses got=%0d exp=2", o_n); end
    checks++;
    if (b_n !== 3202) begin failures++; $display("FAIL overrun_busy got=%0d exp=3202", b_n); end
    checks++;
    if (r_n !== 64) begin failures++; $display("FAIL overrun_reads got=%0d exp=64", r_n); end
    checks++;
    if (l_n !== 2) begin failures++; $display("FAIL overrun_latch got=%0d exp=2", l_n); end
  endtask

  task automatic test_invalid;
`ifdef ROW_STREAMER_BLANK_EN
    int b_n, r_n, l_n, o_n;
    run_row(10'd3, 1'b0, 1'b0, 1'b1, 1'b0, b_n, r_n, l_n, o_n);
    checks++;
    if (b_n !== 3202) begin failures++; $display("FAIL blank_busy got=%0d exp=3202", b_n); end
    checks++;
    if (r_n !== 0) begin failures++; $display("FAIL blank_reads got=%0d exp=0", r_n); end
    checks++;
    if (l_n !== 2) begin failures++; $display("FAIL blank_latch got=%0d exp=2", l_n); end
`else
    int act = 0;
    row = 10'd3; index = 1'b0; valid = 1'b0; rowChange = 1'b1;
    @(negedge clk);
    rowChange = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (busy || memRdEn || overrun || ledLatch) act++;
      @(negedge clk);
    end
    checks++;
    if (act !== 0) begin failures++; $display("FAIL invalid_ignored got=%0d active cycles exp=0", act); end
`endif
    valid = 1'b1;
  endtask

  task automatic test_reset_mid_row;
    int b_n, r_n, l_n, o_n;
    int lat = 0;
    row = 10'd20; index = 1'b1; valid = 1'b1; rowChange = 1'b1;
    @(negedge clk);
    rowChange = 1'b0;
    repeat (500) @(negedge clk);
    #2 nReset = 1'b0;
    #1;
    checks++;
    if ({memAddr, memRdEn, ledClk, ledData, ledLatch, busy, overrun} !== '0) begin
      failures++;
      $display("FAIL mid_reset_outputs got=%h exp=0", {memAddr, memRdEn, ledClk, ledData, ledLatch, busy, overrun});
    end
    @(negedge clk);
    nReset = 1'b1;
    for (int t = 0; t < 10; t++) begin
      if (ledLatch || busy) lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== 0) begin failures++; $display("FAIL mid_reset_quiet got=%0d exp=0", lat); end
    run_row(10'd7, 1'b0, 1'b1, 1'b0, 1'b0, b_n, r_n, l_n, o_n);
    checks++;
    if (b_n !== 3202 || r_n !== 64 || l_n !== 2) begin
      failures++;
      $display("FAIL post_reset_row got busy=%0d rd=%0d latch=%0d exp 3202/64/2", b_n, r_n, l_n);
    end
  endtask

  task automatic test_divider;
    int busy_n = 0, rd_n = 0, latch_n = 0, rises = 0, hi_run = 0, last_rise = -1, bi = 0;
    bit seen = 0;
    bit done_ok = 0;
    logic prev_clk = 1'b0;
    logic [7:0] cur_px = '0;
    row = 10'd2; index = 1'b1; valid = 1'b1; d_rowChange = 1'b1;
    @(negedge clk);
    d_rowChange = 1'b0;
    for (int cyc = 0; cyc < 1000; cyc++) begin
      if (d_busy) begin
        busy_n++;
        seen = 1;
      end else if (seen) begin
        done_ok = 1;
        break;
      end
      if (d_memRdEn) begin
        cur_px = d_pix(2'(rd_n));
        bi = 7;
        rd_n++;
      end
      if (d_ledClk && !prev_clk) begin
        checks++;
        if (bi != 7 && (cyc - last_rise) !== 6) begin
          failures++;
          $display("FAIL div_period got=%0d exp=6", cyc - last_rise);
        end
        checks++;
        if (d_ledData !== cur_px[bi]) begin
          failures++;
          $display("FAIL div_bit got=%b exp=%b", d_ledData, cur_px[bi]);
        end
        last_rise = cyc;
        rises++;
        bi = bi - 1;
      end
      if (d_ledClk) hi_run++;
      if (!d_ledClk && prev_clk) begin
        checks++;
        if (hi_run !== 3) begin failures++; $display("FAIL div_high got=%0d exp=3", hi_run); end
        hi_run = 0;
      end
      if (d_ledLatch) latch_n++;
      prev_clk = d_ledClk;
      @(negedge clk);
    end
    checks++;
    if (!done_ok || busy_n !== 206) begin failures++; $display("FAIL div_busy got=%0d exp=206", busy_n); end
    checks++;
    if (rd_n !== 4 || rises !== 32) begin
      failures++;
      $display("FAIL div_counts got rd=%0d rises=%0d exp 4/32", rd_n, rises);
    end
    checks++;
    if (latch_n !== 6) begin failures++; $display("FAIL div_latch got=%0d exp=6", latch_n); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_invalid();
    test_reset_mid_row();
    test_divider();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
